// File: rtl/cva5_fifo_ext.sv
`default_nettype none
// ============================================================================
// Module   : cva5_fifo_ext
// Brief    : First-word-fall-through synchronous FIFO of any depth, with an
//            occupancy count, almost-full threshold, flush and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module cva5_fifo_ext #(
    parameter int DATA_WIDTH            = 32,
    parameter int FIFO_DEPTH            = 3,
    parameter int ALMOST_FULL_THRESHOLD = FIFO_DEPTH - 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             push,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             pop,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             valid,
    output logic                             full,
    output logic                             almost_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
    input  logic                             clear_errors,
    output logic                             overflow,
    output logic                             underflow
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] c_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_AF    = CW'(ALMOST_FULL_THRESHOLD);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_valid;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_push_drop;
    logic w_pop_ignore;

    // Status decoded only from the registered count, never from push/pop
    assign w_full  = (r_count == c_DEPTH);
    assign w_valid = (r_count != '0);

    assign w_push_acc   = push & ~flush & (~w_full | pop);
    assign w_pop_acc    = pop & ~flush & w_valid;
    assign w_push_drop  = push & ~flush & w_full & ~pop;
    assign w_pop_ignore = pop & ~flush & ~w_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    generate
        if (FIFO_DEPTH > 1) begin : g_ptr_multi
            localparam logic [PW-1:0] c_LAST = PW'(FIFO_DEPTH - 1);

            // Explicit wrap so non-power-of-two depths stay in range
            function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
                return (p == c_LAST) ? '0 : p + 1'b1;
            endfunction

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else if (flush) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push_acc) r_wr_ptr <= f_inc(r_wr_ptr);
                    if (w_pop_acc)  r_rd_ptr <= f_inc(r_rd_ptr);
                end
            end
        end else begin : g_ptr_single
            assign r_wr_ptr = '0;
            assign r_rd_ptr = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_push_acc) - CW'(w_pop_acc);
        end
    end

    // Setting wins over clearing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_push_drop  | (r_overflow  & ~clear_errors);
            r_underflow <= w_pop_ignore | (r_underflow & ~clear_errors);
        end
    end

    assign data_out    = r_mem[r_rd_ptr];
    assign valid       = w_valid;
    assign full        = w_full;
    assign almost_full = (r_count >= c_AF);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire
